// File: rtl/cpu_oci_trace_fifo.sv
// cpu_oci_trace_fifo: circular trace-capture buffer with drop-or-overwrite
// behaviour when full, a sticky overflow flag and a RUN -> DRAIN -> ENDED
// end-of-test sequencer that freezes capture and waits for the consumer
// to empty the buffer.
// Optional feature macro: OCI_TRACE_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter whose value is stored with each accepted word and presented
// on rd_timestamp alongside rd_data.
module cpu_oci_trace_fifo #(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 5,
    parameter int WRAP_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    output logic              test_has_ended,
`ifdef OCI_TRACE_TIMESTAMP_EN
    output logic [31:0]       rd_timestamp,
`endif
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf_flag;
    logic              ended;

    logic empty;
    logic full;
    logic rd_fire;
    logic wr_accept;
    logic wr_overwrite;
    logic wr_drop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign rd_fire = !empty && rd_ready;

    // Write arbitration: capture only while running; a full buffer still
    // accepts when a read frees the head slot in the same cycle, or when
    // overwrite mode sacrifices the oldest entry.
    always_comb begin
        wr_accept    = 1'b0;
        wr_drop      = 1'b0;
        if (wr_valid && state == ST_RUN) begin
            if (!full || rd_fire || (WRAP_MODE != 0)) begin
                wr_accept = 1'b1;
            end else begin
                wr_drop = 1'b1;
            end
        end
        wr_overwrite = wr_accept && full && !rd_fire;
    end

    // Pointers, occupancy and sticky overflow; an overwrite pushes the read
    // pointer past the lost entry so the count stays at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire || wr_overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept && !wr_overwrite, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_overwrite || wr_drop) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    // Storage array; contents are deliberately left uninitialised.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data   = mem[rd_ptr];
    assign rd_valid  = !empty;
    assign dct_count = count;
    assign overflow  = ovf_flag;

    // End-of-test sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: freeze capture on test_ending, finish once the
    // registered count is seen empty, then stay ended until reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (test_ending) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_next = ST_ENDED;
                end
            end
            ST_ENDED: begin
                state_next = ST_ENDED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Registered completion flag, high exactly while in ENDED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ended <= 1'b0;
        end else begin
            ended <= (state_next == ST_ENDED);
        end
    end

    assign test_has_ended = ended;

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [31:0] ts_counter;
    logic [31:0] ts_mem [DEPTH];

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_counter <= '0;
        end else begin
            ts_counter <= ts_counter + 32'd1;
        end
    end

    // Timestamp storage written alongside the data word.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            ts_mem[wr_ptr] <= ts_counter;
        end
    end

    assign rd_timestamp = ts_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_cpu_oci_trace_fifo.sv
// Testbench for cpu_oci_trace_fifo: one drop-mode and one overwrite-mode
// instance share all inputs; a queue-based reference model tracks both.
module tb_cpu_oci_trace_fifo;

    localparam int DW    = 30;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    typedef struct packed {
        logic [31:0]   ts;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          test_ending = 1'b0;

    logic          d_rd_valid, w_rd_valid;
    logic [DW-1:0] d_rd_data, w_rd_data;
    logic [CW-1:0] d_count, w_count;
    logic          d_ended, w_ended;
    logic          d_ovf, w_ovf;
`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [31:0]   d_ts, w_ts;
`endif

    int total = 0;
    int bad = 0;

    ent_t        q_drop[$];
    ent_t        q_wrap[$];
    bit          ov_drop, ov_wrap;
    int          m_state;   // 0 run, 1 drain, 2 ended
    logic [31:0] cyc;

    always #5 clk = ~clk;

    cpu_oci_trace_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .WRAP_MODE(0)) u_drop (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(d_rd_valid), .rd_data(d_rd_data),
        .dct_count(d_count), .test_ending(test_ending), .test_has_ended(d_ended),
`ifdef OCI_TRACE_TIMESTAMP_EN
        .rd_timestamp(d_ts),
`endif
        .overflow(d_ovf)
    );

    cpu_oci_trace_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
        .dct_count(w_count), .test_ending(test_ending), .test_has_ended(w_ended),
`ifdef OCI_TRACE_TIMESTAMP_EN
        .rd_timestamp(w_ts),
`endif
        .overflow(w_ovf)
    );

    task automatic model_clear();
        q_drop.delete();
        q_wrap.delete();
        ov_drop = 1'b0;
        ov_wrap = 1'b0;
        m_state = 0;
        cyc = '0;
    endtask

    // Drive one cycle of inputs, advance the reference model at the edge.
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit te);
        int   n;
        bit   run;
        ent_t e;
        wr_valid = wv;
        wr_data = wd;
        rd_ready = rr;
        test_ending = te;
        @(posedge clk);
        n = q_drop.size();
        run = (m_state == 0);
        e.ts = cyc;
        e.d = wd;
        if (rr && q_drop.size() != 0) void'(q_drop.pop_front());
        if (wv && run) begin
            if (q_drop.size() < DEPTH) q_drop.push_back(e);
            else ov_drop = 1'b1;
        end
        if (rr && q_wrap.size() != 0) void'(q_wrap.pop_front());
        if (wv && run) begin
            if (q_wrap.size() == DEPTH) begin
                void'(q_wrap.pop_front());
                ov_wrap = 1'b1;
            end
            q_wrap.push_back(e);
        end
        if (m_state == 0 && te) m_state = 1;
        else if (m_state == 1 && n == 0) m_state = 2;
        cyc = cyc + 32'd1;
        #1;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        wr_data = '0;
        rd_ready = 1'b0;
        test_ending = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (d_count !== 5'd0) begin bad++; $display("FAIL reset_count_drop got=%0d want=0", d_count); end
        total++; if (w_count !== 5'd0) begin bad++; $display("FAIL reset_count_wrap got=%0d want=0", w_count); end
        total++; if (d_rd_valid !== 1'b0 || w_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b/%b want=0/0", d_rd_valid, w_rd_valid); end
        total++; if (d_ovf !== 1'b0 || w_ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b/%b want=0/0", d_ovf, w_ovf); end
        total++; if (d_ended !== 1'b0 || w_ended !== 1'b0) begin bad++; $display("FAIL reset_ended got=%b/%b want=0/0", d_ended, w_ended); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        step(1'b1, 30'h0, 1'b0, 1'b0);
        total++; if (d_rd_valid !== 1'b1 || d_rd_data !== 30'h0) begin bad++; $display("FAIL first_word valid=%b data=%h want 1/0", d_rd_valid, d_rd_data); end
        for (int i = 1; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        total++; if (d_count !== 5'd16 || w_count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d/%0d want=16", d_count, w_count); end
        for (int i = 0; i < 16; i++) begin
            total++; if (d_rd_data !== DW'(i) || w_rd_data !== DW'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h/%h want=%h", i, d_rd_data, w_rd_data, i); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        total++; if (d_count !== 5'd0 || w_count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d/%0d want=0", d_count, w_count); end
        total++; if (d_rd_valid !== 1'b0 || w_rd_valid !== 1'b0) begin bad++; $display("FAIL drain_rd_valid got=%b/%b want=0", d_rd_valid, w_rd_valid); end
        total++; if (d_ovf !== 1'b0 || w_ovf !== 1'b0) begin bad++; $display("FAIL drain_overflow got=%b/%b want=0", d_ovf, w_ovf); end
    endtask

    task automatic test_full_drop();
        do_reset();
        fill16();
        step(1'b1, 30'h3FFFFFFF, 1'b0, 1'b0);
        total++; if (d_count !== 5'd16) begin bad++; $display("FAIL drop_count got=%0d want=16", d_count); end
        total++; if (d_ovf !== 1'b1) begin bad++; $display("FAIL drop_overflow got=%b want=1", d_ovf); end
        total++; if (d_rd_data !== 30'h0) begin bad++; $display("FAIL drop_head got=%h want=0", d_rd_data); end
        for (int i = 0; i < 16; i++) begin
            total++; if (d_rd_data !== DW'(i)) begin bad++; $display("FAIL drop_read i=%0d got=%h want=%h", i, d_rd_data, i); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        total++; if (d_count !== 5'd0 || d_rd_valid !== 1'b0) begin bad++; $display("FAIL drop_empty count=%0d valid=%b want 0/0", d_count, d_rd_valid); end
    endtask

    task automatic test_full_overwrite();
        do_reset();
        fill16();
        step(1'b1, 30'h10, 1'b0, 1'b0);
        total++; if (w_ovf !== 1'b1) begin bad++; $display("FAIL ovw_overflow got=%b want=1", w_ovf); end
        total++; if (w_count !== 5'd16) begin bad++; $display("FAIL ovw_count got=%0d want=16", w_count); end
        total++; if (w_rd_data !== 30'h1) begin bad++; $display("FAIL ovw_head got=%h want=1", w_rd_data); end
        for (int i = 1; i <= 16; i++) begin
            total++; if (w_rd_data !== DW'(i)) begin bad++; $display("FAIL ovw_read i=%0d got=%h want=%h", i, w_rd_data, i); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        total++; if (w_count !== 5'd0) begin bad++; $display("FAIL ovw_empty got=%0d want=0", w_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill16();
        step(1'b1, 30'h20, 1'b1, 1'b0);
        total++; if (d_count !== 5'd16 || w_count !== 5'd16) begin bad++; $display("FAIL rw_full_count got=%0d/%0d want=16", d_count, w_count); end
        total++; if (d_ovf !== 1'b0 || w_ovf !== 1'b0) begin bad++; $display("FAIL rw_full_overflow got=%b/%b want=0", d_ovf, w_ovf); end
        for (int i = 1; i <= 16; i++) begin
            logic [DW-1:0] exp;
            exp = (i == 16) ? 30'h20 : DW'(i);
            total++; if (d_rd_data !== exp || w_rd_data !== exp) begin bad++; $display("FAIL rw_read i=%0d got=%h/%h want=%h", i, d_rd_data, w_rd_data, exp); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
        step(1'b1, 30'hA3, 1'b0, 1'b1);
        total++; if (d_count !== 5'd4 || w_count !== 5'd4) begin bad++; $display("FAIL drn_count got=%0d/%0d want=4", d_count, w_count); end
        step(1'b1, 30'hBB, 1'b0, 1'b1);
        total++; if (d_count !== 5'd4 || d_ovf !== 1'b0) begin bad++; $display("FAIL drn_ignore count=%0d ovf=%b want 4/0", d_count, d_ovf); end
        for (int i = 0; i < 4; i++) begin
            total++; if (d_rd_data !== DW'(32'hA0 + i) || d_ended !== 1'b0) begin bad++; $display("FAIL drn_read i=%0d got=%h ended=%b want=%h/0", i, d_rd_data, d_ended, 32'hA0 + i); end
            step(1'b1, 30'hCC, 1'b1, 1'b0);
        end
        total++; if (d_count !== 5'd0 || d_ended !== 1'b0) begin bad++; $display("FAIL drn_zero count=%0d ended=%b want 0/0", d_count, d_ended); end
        step(1'b1, 30'hDD, 1'b0, 1'b0);
        total++; if (d_ended !== 1'b1 || w_ended !== 1'b1) begin bad++; $display("FAIL drn_ended got=%b/%b want=1", d_ended, w_ended); end
        total++; if (d_count !== 5'd0 || d_rd_valid !== 1'b0) begin bad++; $display("FAIL ended_nowrite count=%0d valid=%b want 0/0", d_count, d_rd_valid); end
        step(1'b0, '0, 1'b1, 1'b1);
        total++; if (d_ended !== 1'b1 || d_count !== 5'd0) begin bad++; $display("FAIL ended_hold ended=%b count=%0d want 1/0", d_ended, d_count); end
        // Empty buffer: ended after the second edge.
        do_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        total++; if (d_ended !== 1'b0) begin bad++; $display("FAIL empty_drain_edge1 got=%b want=0", d_ended); end
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (d_ended !== 1'b1) begin bad++; $display("FAIL empty_drain_edge2 got=%b want=1", d_ended); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        fill16();
        step(1'b1, 30'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (d_count !== 5'd15 || d_ovf !== 1'b1) begin bad++; $display("FAIL mid_pre count=%0d ovf=%b want 15/1", d_count, d_ovf); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (d_count !== 5'd0 || w_count !== 5'd0) begin bad++; $display("FAIL mid_async_count got=%0d/%0d want=0", d_count, w_count); end
        total++; if (d_rd_valid !== 1'b0 || d_ovf !== 1'b0 || w_ovf !== 1'b0 || d_ended !== 1'b0) begin bad++; $display("FAIL mid_async_flags valid=%b ovf=%b/%b ended=%b want 0", d_rd_valid, d_ovf, w_ovf, d_ended); end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        test_ending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step(1'b1, 30'h55, 1'b0, 1'b0);
        total++; if (d_count !== 5'd1 || d_rd_data !== 30'h55 || w_rd_data !== 30'h55) begin bad++; $display("FAIL mid_resume count=%0d data=%h/%h want 1/55", d_count, d_rd_data, w_rd_data); end
    endtask

    task automatic test_random();
        int wbias;
        int rbias;
        do_reset();
        wbias = 60;
        rbias = 40;
        for (int it = 0; it < 3000; it++) begin
            if (it % 150 == 0) begin
                wbias = $urandom_range(20, 95);
                rbias = $urandom_range(5, 90);
            end
            if (m_state == 2 && $urandom_range(0, 9) == 0) do_reset();
            step($urandom_range(0, 99) < wbias, DW'($urandom), $urandom_range(0, 99) < rbias,
                 $urandom_range(0, 599) == 0);
            total++; if (d_count !== CW'(q_drop.size()) || w_count !== CW'(q_wrap.size())) begin bad++; $display("FAIL rnd_count it=%0d got=%0d/%0d want=%0d/%0d", it, d_count, w_count, q_drop.size(), q_wrap.size()); end
            total++; if (d_rd_valid !== (q_drop.size() != 0) || w_rd_valid !== (q_wrap.size() != 0)) begin bad++; $display("FAIL rnd_valid it=%0d got=%b/%b", it, d_rd_valid, w_rd_valid); end
            total++; if (d_ovf !== ov_drop || w_ovf !== ov_wrap) begin bad++; $display("FAIL rnd_overflow it=%0d got=%b/%b want=%b/%b", it, d_ovf, w_ovf, ov_drop, ov_wrap); end
            total++; if (d_ended !== (m_state == 2) || w_ended !== (m_state == 2)) begin bad++; $display("FAIL rnd_ended it=%0d got=%b/%b want=%b", it, d_ended, w_ended, m_state == 2); end
            if (q_drop.size() != 0) begin
                total++; if (d_rd_data !== q_drop[0].d) begin bad++; $display("FAIL rnd_data_drop it=%0d got=%h want=%h", it, d_rd_data, q_drop[0].d); end
`ifdef OCI_TRACE_TIMESTAMP_EN
                total++; if (d_ts !== q_drop[0].ts) begin bad++; $display("FAIL rnd_ts_drop it=%0d got=%0d want=%0d", it, d_ts, q_drop[0].ts); end
`endif
            end
            if (q_wrap.size() != 0) begin
                total++; if (w_rd_data !== q_wrap[0].d) begin bad++; $display("FAIL rnd_data_wrap it=%0d got=%h want=%h", it, w_rd_data, q_wrap[0].d); end
`ifdef OCI_TRACE_TIMESTAMP_EN
                total++; if (w_ts !== q_wrap[0].ts) begin bad++; $display("FAIL rnd_ts_wrap it=%0d got=%0d want=%0d", it, w_ts, q_wrap[0].ts); end
`endif
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_drain();
        test_full_drop();
        test_full_overwrite();
        test_back_to_back();
        test_drain();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_oci_trace_fifo.md
CPU_OCI_TRACE_FIFO -- requirements
Module: cpu_oci_trace_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 30: trace word width, 1..64.
REQ-002 SHALL have parameter DEPTH, default 16: entries, power of two, 2..256.
REQ-003 SHALL have parameter CNT_W, default 5: count width, equal to log2(DEPTH)+1.
REQ-004 SHALL have parameter WRAP_MODE, default 0: 0 = drop new writes when full, 1 = overwrite the oldest entry.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wr_valid, input, 1 bit: trace word offered.
REQ-008 SHALL have port wr_data, input, DATA_W bits: trace word.
REQ-009 SHALL have port rd_ready, input, 1 bit: consumer accepts the head entry.
REQ-010 SHALL have port rd_valid, output, 1 bit: head entry present.
REQ-011 SHALL have port rd_data, output, DATA_W bits: oldest stored entry.
REQ-012 SHALL have port dct_count, output, CNT_W bits: stored entries, 0..DEPTH.
REQ-013 SHALL have port test_ending, input, 1 bit: request to freeze capture and drain.
REQ-014 SHALL have port test_has_ended, output, 1 bit: drain complete.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set when any entry is lost.

Function
REQ-016 SHALL implement a circular buffer with write and read pointers of log2(DEPTH) bits that wrap DEPTH-1 -> 0 with no bubble.
REQ-017 SHALL accept a write when wr_valid=1, state is RUN, and the buffer is not full or WRAP_MODE=1.
REQ-018 SHALL, on full + wr_valid + WRAP_MODE=0 + no read that cycle: drop the word, keep count at DEPTH, set overflow.
REQ-019 SHALL, on full + wr_valid + WRAP_MODE=1 + no read that cycle: overwrite the oldest entry, advance both pointers, keep count at DEPTH, set overflow.
REQ-020 SHALL treat a same-cycle write and read handshake as: count unchanged, no overflow, including when full.
REQ-021 SHALL provide no bypass: a word written into an empty buffer gives rd_valid=1 one cycle later.
REQ-022 SHALL drive rd_valid = (dct_count != 0); a read occurs when rd_valid=1 and rd_ready=1, and rd_data shows the next entry one cycle later.
REQ-023 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0, except in a WRAP_MODE=1 overwrite, where rd_data changes to the new head.
REQ-024 SHALL implement an FSM RUN -> DRAIN -> ENDED:
  - RUN -> DRAIN at the edge where test_ending=1 is sampled; a write in that same cycle is accepted.
  - In DRAIN, writes are ignored and do not set overflow; reads continue.
  - DRAIN -> ENDED at the first edge where dct_count=0 is sampled.
  - ENDED is terminal until reset, and reads of an empty buffer are no-ops.
  - test_ending in DRAIN or ENDED has no effect.
REQ-025 SHALL register test_has_ended and assert it exactly while in ENDED.
REQ-026 SHALL, when test_ending arrives with an empty buffer, assert test_has_ended after the second rising edge (RUN -> DRAIN -> ENDED).

Reset
REQ-027 SHALL, on reset assertion, immediately clear pointers, set dct_count=0, rd_valid=0, overflow=0, test_has_ended=0, and state=RUN, regardless of any drain in progress.
REQ-028 SHALL leave storage contents uninitialised; rd_data is don't-care while rd_valid=0.
REQ-029 SHALL resume normal operation on the first rising edge after reset deassertion.

Configuration
REQ-030 SHALL, with OCI_TRACE_TIMESTAMP_EN defined, add:
  - a 32-bit free-running cycle counter, reset to 0, wrapping 0xFFFFFFFF -> 0;
  - output rd_timestamp[31:0], stored alongside each accepted entry with the counter value at write acceptance, following rd_data timing.
REQ-031 SHALL, without OCI_TRACE_TIMESTAMP_EN, omit the port and the counter; all other behaviour is identical.

Verification
REQ-032 SHALL cover fill/drain: DEPTH=16, write 0x0..0xF with rd_ready=0 -> dct_count=16; then rd_ready=1 -> 0x0..0xF in order, count reaches 0, rd_valid=0.
REQ-033 SHALL cover full drop: WRAP_MODE=0, full, write 0x3FFFFFFF -> count 16, overflow=1, the value is never read.
REQ-034 SHALL cover full overwrite: WRAP_MODE=1, full with 0x0..0xF, write 0x10 -> overflow=1, reads return 0x1..0x10.
REQ-035 SHALL cover simultaneous read and write when full: write 0x20 with a read -> count stays 16, overflow stays 0.
REQ-036 SHALL cover drain: 3 entries, pulse test_ending with a write in the same cycle -> 4 entries readable, later writes ignored, test_has_ended=1 one edge after count reaches 0.
REQ-037 SHALL cover mid-drain reset: assert reset in DRAIN -> all outputs cleared asynchronously, state RUN, new writes accepted after deassertion.
